// File: rtl/scan_resp_pkg.sv
// scan_resp_pkg: FSM states, MISR constants and default field width for scan_resp_checker
package scan_resp_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
   localparam logic [15:0] MISR_POLY = 16'h1021;
   localparam logic [15:0] MISR_SEED = 16'hFFFF;
   localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/scan_resp_misr.sv
// scan_resp_misr: 16-bit MISR (x^16+x^12+x^5+1) compacting W masked scan bits per enabled cycle
module scan_resp_misr
   import scan_resp_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         init,
   input  logic         en,
   input  logic [W-1:0] data,
   output logic [15:0]  sig
);
   always_ff @(posedge clk)
      if (rst || init) sig <= MISR_SEED;
      else if (en) sig <= {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0) ^ 16'(data);
endmodule

// File: rtl/scan_resp_checker.sv
// scan_resp_checker: masked scan-out compare FSM; SCAN_RESP_CHECKER_MISR_EN adds misr_sig
module scan_resp_checker
   import scan_resp_pkg::*;
#(
   parameter int NUM_CHAINS = 4,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  shift_en,
   input  logic [NUM_CHAINS-1:0] scan_out,
   input  logic [NUM_CHAINS-1:0] exp_data,
   input  logic [NUM_CHAINS-1:0] exp_mask,
   input  logic [CNT_W-1:0]      pattern_len,
   input  logic [CNT_W-1:0]      num_patterns,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [CNT_W-1:0]      fail_count,
   output logic [CNT_W-1:0]      first_fail_pattern,
   output logic [CNT_W-1:0]      first_fail_cycle,
   output logic [NUM_CHAINS-1:0] first_fail_chain
`ifdef SCAN_RESP_CHECKER_MISR_EN
   ,
   output logic [15:0]           misr_sig
`endif
);
   state_t                  state;
   logic [CNT_W-1:0]        len_q, npat_q, cyc, pat;
   logic [NUM_CHAINS-1:0]   mm;
   logic [CNT_W:0]          pop, sum;
   logic [CNT_W-1:0]        fc_next;
   logic                    go, cmp;
   assign go  = (state == IDLE) && start;
   assign cmp = (state == SHIFT) && shift_en;
   // !== makes an unknown observed bit on a masked-in chain count as a mismatch
   always_comb begin
      mm  = '0;
      pop = '0;
      for (int i = 0; i < NUM_CHAINS; i++) begin
         mm[i] = exp_mask[i] && ((scan_out[i] ^ exp_data[i]) !== 1'b0);
         pop   = pop + (CNT_W+1)'(mm[i]);
      end
      sum     = {1'b0, fail_count} + pop;
      fc_next = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
   end
   always_ff @(posedge clock)
      if (reset) begin
         state              <= IDLE;
         len_q              <= '0;
         npat_q             <= '0;
         cyc                <= '0;
         pat                <= '0;
         busy               <= 1'b0;
         done               <= 1'b0;
         pass               <= 1'b0;
         fail_count         <= '0;
         first_fail_pattern <= '0;
         first_fail_cycle   <= '0;
         first_fail_chain   <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               len_q              <= pattern_len;
               npat_q             <= num_patterns;
               cyc                <= '0;
               pat                <= '0;
               fail_count         <= '0;
               first_fail_pattern <= '0;
               first_fail_cycle   <= '0;
               first_fail_chain   <= '0;
               if (pattern_len == '0 || num_patterns == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
                  pass  <= 1'b1;
               end else begin
                  state <= SHIFT;
                  busy  <= 1'b1;
                  pass  <= 1'b0;
               end
            end
            SHIFT: if (shift_en) begin
               fail_count <= fc_next;
               if (mm != '0 && fail_count == '0) begin
                  first_fail_pattern <= pat;
                  first_fail_cycle   <= cyc;
                  first_fail_chain   <= mm;
               end
               if (cyc == len_q - 1'b1) begin
                  cyc <= '0;
                  if (pat == npat_q - 1'b1) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (fc_next == '0);
                  end else begin
                     pat   <= pat + 1'b1;
                     state <= GAP;
                  end
               end else cyc <= cyc + 1'b1;
            end
            GAP: state <= SHIFT;
            default: begin
               state <= IDLE;
               done  <= 1'b0;
            end
         endcase
      end
`ifdef SCAN_RESP_CHECKER_MISR_EN
   scan_resp_misr #(.W(NUM_CHAINS)) u_misr (
      .clk (clock),
      .rst (reset),
      .init(go),
      .en  (cmp),
      .data(scan_out & exp_mask),
      .sig (misr_sig)
   );
`endif
endmodule

// File: tb/tb_scan_resp_checker.sv
// tb_scan_resp_checker: directed self-checking bench for scan_resp_checker
module tb_scan_resp_checker;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        shift_en = 1'b0;
   logic [3:0]  scan_out = '0, exp_data = '0, exp_mask = '0;
   logic [15:0] pattern_len = '0, num_patterns = '0;
   logic        busy, done, pass;
   logic [15:0] fail_count, first_fail_pattern, first_fail_cycle;
   logic [3:0]  first_fail_chain;
`ifdef SCAN_RESP_CHECKER_MISR_EN
   logic [15:0] misr_sig;
   logic [15:0] misr_exp;
`endif
   int checks = 0, errors = 0;
   int n;
   logic saw_done;
   scan_resp_checker dut (
      .clock(clock), .reset(reset), .start(start), .shift_en(shift_en),
      .scan_out(scan_out), .exp_data(exp_data), .exp_mask(exp_mask),
      .pattern_len(pattern_len), .num_patterns(num_patterns),
      .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
      .first_fail_pattern(first_fail_pattern), .first_fail_cycle(first_fail_cycle),
      .first_fail_chain(first_fail_chain)
`ifdef SCAN_RESP_CHECKER_MISR_EN
      , .misr_sig(misr_sig)
`endif
   );
   always #5 clock = ~clock;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // t counts cycles after the edge that accepts start; n = edges from start to done
   task automatic run(input int len, input int pats, input int err_t, input logic [3:0] err,
                      input logic [3:0] mask, input int stall_from, input int stall_n,
                      input int gap_t, input int start_t, output int nn);
      nn = -1;
      @(posedge clock); #1;
      pattern_len = 16'(len); num_patterns = 16'(pats); exp_mask = mask;
      shift_en = 1'b1; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0; pattern_len = 16'd2; num_patterns = 16'd7;
      if (done) nn = 1;
      for (int t = 0; nn < 0 && t < 20000; t++) begin
         shift_en = !(t >= stall_from && t < stall_from + stall_n);
         exp_data = 4'(t * 5 + 3);
         scan_out = exp_data ^ ((err_t == -2 || t == err_t) ? err : 4'h0)
                             ^ ((!shift_en || t == gap_t) ? 4'hF : 4'h0);
         start = (t == start_t);
         @(posedge clock); #1;
         if (done) nn = t + 2;
      end
      start = 1'b0; shift_en = 1'b0;
   endtask
   initial begin
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_fc", fail_count, 0);
      check("rst_ffp", first_fail_pattern, 0);
      check("rst_ffc", first_fail_cycle, 0);
      check("rst_ffch", first_fail_chain, 0);
`ifdef SCAN_RESP_CHECKER_MISR_EN
      check("rst_misr", misr_sig, 16'hFFFF);
`endif
      // clean 2x8 run, garbage presented in the gap cycle
      run(8, 2, -1, 4'h0, 4'hF, 1000, 0, 8, -1, n);
      check("clean_lat", n, 18);
      check("clean_pass", pass, 1);
      check("clean_fc", fail_count, 0);
      check("clean_busy", busy, 0);
      // error at pattern 1 cycle 3, with a start pulse mid-run
      run(8, 2, 12, 4'b0101, 4'hF, 1000, 0, -1, 14, n);
      check("err_lat", n, 18);
      check("err_fc", fail_count, 2);
      check("err_ffp", first_fail_pattern, 1);
      check("err_ffc", first_fail_cycle, 3);
      check("err_ffch", first_fail_chain, 4'b0101);
      check("err_pass", pass, 0);
      // same error masked out
      run(8, 2, 12, 4'b0101, 4'b1010, 1000, 0, -1, -1, n);
      check("mask_lat", n, 18);
      check("mask_fc", fail_count, 0);
      check("mask_pass", pass, 1);
      // 5-cycle stall, error on shift index 2
      run(4, 1, 7, 4'b0101, 4'hF, 1, 5, -1, -1, n);
      check("stall_lat", n, 10);
      check("stall_fc", fail_count, 2);
      check("stall_ffp", first_fail_pattern, 0);
      check("stall_ffc", first_fail_cycle, 2);
      check("stall_ffch", first_fail_chain, 4'b0101);
      // zero-length configurations
      run(0, 3, -1, 4'h0, 4'hF, 1000, 0, -1, -1, n);
      check("len0_lat", n, 1);
      check("len0_pass", pass, 1);
      check("len0_fc", fail_count, 0);
      run(5, 0, -1, 4'h0, 4'hF, 1000, 0, -1, -1, n);
      check("pat0_lat", n, 1);
      check("pat0_pass", pass, 1);
      // reset three cycles into a run
      @(posedge clock); #1;
      pattern_len = 16'd8; num_patterns = 16'd1; exp_mask = 4'hF; shift_en = 1'b1;
      exp_data = 4'h0; scan_out = 4'hF; start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      repeat (3) @(posedge clock);
      #1 check("mid_busy", busy, 1);
      check("mid_fc", fail_count, 12);
      reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_fc", fail_count, 0);
      saw_done = 1'b0;
      repeat (15) begin
         @(posedge clock); #1 saw_done |= done;
      end
      check("abort_nodone", saw_done, 0);
      check("abort_idle_busy", busy, 0);
      shift_en = 1'b0;
      // every chain failing every cycle: 16400*4 overflows the 16-bit count
      run(16400, 1, -2, 4'hF, 4'hF, 100000, 0, -1, -1, n);
      check("sat_lat", n, 16401);
      check("sat_fc", fail_count, 16'hFFFF);
      check("sat_ffc", first_fail_cycle, 0);
      check("sat_ffch", first_fail_chain, 4'hF);
      check("sat_pass", pass, 0);
`ifdef SCAN_RESP_CHECKER_MISR_EN
      // fully masked stream: signature is 16 pure LFSR steps from the seed
      run(8, 2, 3, 4'hF, 4'h0, 1000, 0, 8, -1, n);
      misr_exp = 16'hFFFF;
      repeat (16) misr_exp = {misr_exp[14:0], 1'b0} ^ (misr_exp[15] ? 16'h1021 : 16'h0);
      check("misr_lat", n, 18);
      check("misr_pass", pass, 1);
      check("misr_sig", misr_sig, misr_exp);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
